// File: rtl/reg_file_mem.sv
// Small register-file memory with one write and one registered read port, plus a
// self-sequenced clear that zeroes one word per cycle while busy is high.
module reg_file_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr,
    input  logic             clr,
    output logic [WIDTH-1:0] rdata,
    output logic             rd_valid,
    output logic             busy
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             cmd_ok;
    logic             rd_accept;
    logic             wr_accept;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    // clr in IDLE takes priority over any access issued in the same cycle.
    assign busy      = (state == CLEAR);
    assign cmd_ok    = (state == IDLE) && !clr;
    assign rd_accept = cmd_ok && rd_en;
    assign wr_accept = cmd_ok && wr_en && ({1'b0, waddr} < DEPTH_EXT);

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == LAST_IDX) state_next = IDLE;
            IDLE:    if (clr) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Single write port shared between the clear sequencer and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_accept) begin
            mem_we    = 1'b1;
            mem_waddr = waddr;
            mem_wdata = wdata;
        end
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM/flop arrays;
    // zeroing is done by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reading the array before the write lands gives old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rdata <= ({1'b0, raddr} < DEPTH_EXT) ? mem[raddr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mem.sv
// Self-checking bench for reg_file_mem: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_reg_file_mem;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic [AW-1:0]    raddr;
    logic             clr;
    logic [WIDTH-1:0] rdata;
    logic             rd_valid;
    logic             busy;

    always #5 clk = ~clk;

    reg_file_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .raddr    (raddr),
        .clr      (clr),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: remaining clear edges, word contents, and the last read result.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_clear_left = DEPTH;
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic i_rst, input logic i_clr, input logic i_wr,
                        input logic [AW-1:0] i_wa, input logic [WIDTH-1:0] i_wd,
                        input logic i_rd, input logic [AW-1:0] i_ra);
        rst = i_rst; clr = i_clr; wr_en = i_wr; waddr = i_wa; wdata = i_wd;
        rd_en = i_rd; raddr = i_ra;
        @(posedge clk);
        if (i_rst) begin
            m_clear_left = DEPTH;
            m_rdata      = '0;
            m_valid      = 1'b0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            m_valid = 1'b0;
            if (m_clear_left == 0) begin
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else if (i_clr) begin
            m_clear_left = DEPTH;
            m_valid      = 1'b0;
        end else begin
            m_valid = i_rd;
            if (i_rd) m_rdata = (int'(i_ra) < DEPTH) ? m_mem[i_ra] : '0;
            if (i_wr && int'(i_wa) < DEPTH) m_mem[i_wa] = i_wd;
        end
        #1;
        check("busy", 32'(busy), 32'(m_clear_left > 0));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
    endtask

    // Counts busy-high samples from the current cycle through the next six idle edges.
    task automatic count_busy(input string tag, input int exp);
        int n;
        n = int'(busy);
        repeat (6) begin
            idle();
            n += int'(busy);
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; waddr = '0; wdata = '0; rd_en = 1'b0; raddr = '0;

        // Reset then idle: busy lasts DEPTH cycles, all words read back zero.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check("reset_rdata", 32'(rdata), 32'h0);
        count_busy("busy_after_reset", 4);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        idle();

        // Write pattern then back-to-back read-back.
        wr(2'd0, 4'b0000);
        wr(2'd1, 4'b0101);
        wr(2'd2, 4'b1010);
        wr(2'd3, 4'b1111);
        rd(2'd0);
        rd(2'd1);
        check("b2b_rd1", 32'(rdata), 32'h5);
        rd(2'd2);
        rd(2'd3);
        check("b2b_rd3", 32'(rdata), 32'hF);
        idle();
        check("rdata_hold", 32'(rdata), 32'hF);

        // Same-address collision returns old data, next read sees new.
        step(1'b0, 1'b0, 1'b1, 2'd2, 4'b0011, 1'b1, 2'd2);
        check("collision_old", 32'(rdata), 32'hA);
        rd(2'd2);
        check("collision_new", 32'(rdata), 32'h3);

        // clr beats a simultaneous write.
        step(1'b0, 1'b1, 1'b1, 2'd1, 4'b0110, 1'b0, '0);
        count_busy("busy_after_clr", 4);
        rd(2'd1);
        check("clr_drops_write", 32'(rdata), 32'h0);

        // Accesses while busy are ignored.
        wr(2'd0, 4'b1001);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 2'd0);
        step(1'b0, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 2'd0);
        repeat (4) idle();
        rd(2'd0);
        check("busy_access_ignored", 32'(rdata), 32'h0);

        // Reset mid-clear restarts the full sequence.
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle();
        idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        count_busy("busy_after_midclear_rst", 4);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0), 1'($urandom),
                 AW'($urandom), WIDTH'($urandom), 1'($urandom), AW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
